counter_share_arbiter: RTL and testbench
========================================

Name: counter_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4-bit counter (ports reset/cin/clk/q/cout) among N requesters. Each requester asks for a delay of T counter ticks (0..15). The arbiter grants the counter to one requester, clears it, enables counting until q equals T, then pulses done to the owner and releases the counter. It sits between requesting FSMs and a single `counter` instance.

Parameters:
N, 4, number of requesters (2..8)
CW, 4, counter width; must match the counter's q width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  N  per-requester request; hold high until done or abort
tgt  in  N*CW  per-requester target count; slice i is tgt[i*CW +: CW]
gnt  out  N  one-hot grant, registered
done  out  N  one-cycle completion pulse to the owner, registered
busy  out  1  high whenever state != IDLE
err  out  1  sticky; cnt_cout was seen while in COUNT
cnt_clr  out  1  drives counter reset input (active-high, synchronous clear)
cnt_en  out  1  drives counter cin
cnt_q  in  CW  counter q
cnt_cout  in  1  counter cout

Behaviour:
- Reset (reset=0, async): state=IDLE, gnt=0, done=0, err=0, rr_ptr=0, owner=0, tgt_lat=0. cnt_clr=1 while in reset, so the counter is held clear.
- States: IDLE, CLEAR, COUNT, DONE.
- IDLE:
  - If req!=0, select the first requester with req=1, scanning from rr_ptr upward modulo N.
  - Latch owner and tgt_lat=tgt[owner]. Set gnt[owner]=1. Next state CLEAR.
  - Otherwise stay in IDLE.
- CLEAR: cnt_clr=1, cnt_en=0 for exactly one cycle. Next state COUNT. The counter reads q=0 in the first COUNT cycle.
- COUNT:
  - cnt_en = (cnt_q != tgt_lat), combinational. The counter therefore stops exactly at tgt_lat.
  - When cnt_q==tgt_lat, next state is DONE.
- DONE:
  - done[owner]=1 for one cycle, gnt=0, rr_ptr=(owner+1) mod N. Next state IDLE.
  - The owner must drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- cnt_en=0 in every state except COUNT. cnt_clr=0 in every state except CLEAR and reset.
- Latency: req seen in IDLE at cycle 0 -> gnt at cycle 1 -> done pulse at cycle T+3. T=0 gives done at cycle 3 with no count enable.
- Abort: if req[owner] drops during CLEAR or COUNT:
  - next state IDLE, gnt=0, no done pulse, rr_ptr=owner+1.
  - The counter keeps its value; the next grant re-clears it.
- Target stability: changes to tgt after the grant are ignored; tgt_lat is used.
- err: cnt_cout=1 while in COUNT sets err. It stays set until reset. Wrap-around is not possible with a correct counter since T<=15. No state effect.
- Priority: strict round-robin. At most one gnt bit is ever high. Non-owner req changes during a grant are only sampled in the next IDLE.
- Reset mid-operation: immediate return to reset values. Any pending done is lost.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, CLEAR=2'd1, COUNT=2'd2, DONE=2'd3) and CW default.
- One natural sub-module: rr_pick. It is combinational and maps (req, rr_ptr) to a one-hot grant, a binary index and a valid flag. It is reusable by other arbiters.
- The counter itself is not instantiated here; the bench instantiates `counter` and wires it to the cnt_* ports.

Test Plan:
- Single request: req=0001, tgt0=5. Expect gnt=0001 at cycle 1, cnt_clr at cycle 1, cnt_q counts 0..5, cnt_en low once q=5, done=0001 at cycle 8, busy low at cycle 9.
- Zero target: req=0010, tgt1=0. Expect cnt_en never high and done=0010 at cycle 3.
- Round robin: req=1111 held, all tgt=2. Expect grant order 0,1,2,3,0 with one-hot gnt and done spacing of 6 cycles, including 1 IDLE cycle per grant.
- Abort: req0 with tgt=10, then req0 dropped when cnt_q=4 while req2=1. Expect no done[0], gnt=0100 two cycles later, cnt_clr re-asserted, and req2 completing normally.
- Async reset mid-COUNT: assert reset=0 off-edge at cnt_q=7. Expect gnt, done, busy and err all 0 immediately, cnt_clr=1; after release, IDLE with rr_ptr=0.
- err path: force cnt_cout=1 for one cycle during COUNT. Expect err=1 and still set after the next done; cleared only by reset.

Source files
------------

// File: rtl/counter_share_arbiter_pkg.sv
// Shared types for the counter-sharing arbiter.
// State encoding and default counter width.
package counter_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW_DEF = 4;

endpackage

// File: rtl/counter.sv
// Shared up-counter: synchronous active-high clear,
// count enable and carry out.
module counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cin,
  output logic [CW-1:0] q,
  output logic          cout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (cin) begin
      q <= q + CW'(1);
    end
  end

  assign cout = cin & (&q);

endmodule

// File: rtl/counter_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req
// at or above ptr, modulo N.
module counter_share_arbiter_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] j;

  // Scan downward so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter lending one counter to N
// requesters for a T-tick delay each.
module counter_share_arbiter
  import counter_share_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] tgt,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            err,
  output logic            cnt_clr,
  output logic            cnt_en,
  input  logic [CW-1:0]   cnt_q,
  input  logic            cnt_cout
);

  localparam int IW = $clog2(N);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] nxt_ptr;
  logic [CW-1:0] tgt_lat;
  logic [CW-1:0] tgt_pick;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          own_req;

  counter_share_arbiter_rr_pick #(
    .N(N)
  ) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .vld(pick_vld)
  );

  always_comb begin
    tgt_pick = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == IW'(i)) begin
        tgt_pick = tgt[i*CW +: CW];
      end
    end
  end

  assign own_req = req[owner];
  assign nxt_ptr = (owner == IW'(N - 1)) ?
                   '0 : owner + IW'(1);

  assign busy    = (state != IDLE);
  // Counter is held clear through reset as well.
  assign cnt_clr = !reset || (state == CLEAR);
  assign cnt_en  = (state == COUNT) &&
                   (cnt_q != tgt_lat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rr_ptr  <= '0;
      owner   <= '0;
      tgt_lat <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            owner   <= pick_idx;
            tgt_lat <= tgt_pick;
            gnt     <= pick_gnt;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (!own_req) begin
            gnt    <= '0;
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end else begin
            state  <= COUNT;
          end
        end
        COUNT: begin
          // An abort wins over a coincident finish.
          if (!own_req) begin
            gnt    <= '0;
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end else if (cnt_q == tgt_lat) begin
            done   <= gnt;
            gnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          done   <= '0;
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if ((state == COUNT) && cnt_cout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter with a real counter
// and a timeline-based reference model.
module tb_counter_share_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] tgt;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic            err;
  logic            cnt_clr;
  logic            cnt_en;
  logic [CW-1:0]   cnt_q;
  logic            cnt_cout;
  logic            cout_c;
  logic            frc;

  int checks = 0;
  int errors = 0;

  // Model: active flag, k = cycles since grant edge.
  bit          m_act;
  int          m_k;
  int          m_own;
  int          m_T;
  int          m_ptr;
  bit          m_err;
  logic [N-1:0] exp_done;

  counter_share_arbiter #(
    .N(N),
    .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .tgt(tgt),
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .err(err),
    .cnt_clr(cnt_clr),
    .cnt_en(cnt_en),
    .cnt_q(cnt_q),
    .cnt_cout(cnt_cout)
  );

  counter #(
    .CW(CW)
  ) u_cnt (
    .clk(clk),
    .reset(cnt_clr),
    .cin(cnt_en),
    .q(cnt_q),
    .cout(cout_c)
  );

  assign cnt_cout = cout_c | frc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    for (int b = 0; b < N; b++) begin
      if (b == i) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic compare();
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    int eq;
    eg = (m_act && m_k <= m_T + 2) ? oh(m_own) : '0;
    ed = (m_act && m_k == m_T + 3) ? oh(m_own) : '0;
    exp_done = ed;
    chk("gnt", int'(gnt), int'(eg));
    chk("done", int'(done), int'(ed));
    chk("busy", int'(busy), int'(m_act));
    chk("err", int'(err), int'(m_err));
    chk("cnt_clr", int'(cnt_clr),
        int'(!reset || (m_act && m_k == 1)));
    chk("cnt_en", int'(cnt_en),
        int'(m_act && m_k >= 2 && m_k <= m_T + 1));
    chk("onehot", int'($onehot0(gnt)), 1);
    if (reset && m_act && m_k >= 2) begin
      eq = (m_k - 2 > m_T) ? m_T : m_k - 2;
      chk("cnt_q", int'(cnt_q), eq);
    end
  endtask

  task automatic model_reset();
    m_act = 0;
    m_k   = 0;
    m_own = 0;
    m_T   = 0;
    m_ptr = 0;
    m_err = 0;
  endtask

  // One clock: model sees pre-edge inputs at negedge.
  task automatic tick();
    logic [N-1:0] r;
    int s;
    bit f;
    @(negedge clk);
    r = req;
    if (!reset) begin
      model_reset();
    end else begin
      if (m_act && m_k >= 2 && m_k <= m_T + 2 && cnt_cout)
        m_err = 1;
      if (!m_act) begin
        f = 0;
        for (int i = 0; i < N; i++) begin
          s = (m_ptr + i) % N;
          if (!f && r[s]) begin
            f = 1;
            m_own = s;
          end
        end
        if (f) begin
          m_act = 1;
          m_k   = 1;
          m_T   = int'(tgt[m_own*CW +: CW]);
        end
      end else if (m_k <= m_T + 2 && !r[m_own]) begin
        m_act = 0;
        m_ptr = (m_own + 1) % N;
      end else if (m_k == m_T + 3) begin
        m_act = 0;
        m_ptr = (m_own + 1) % N;
      end else begin
        m_k++;
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic int idx_of(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  typedef struct {
    logic [N-1:0] r;
    int           t;
    int           own;
    int           done_cyc;
    int           en_cyc;
  } vec_t;

  vec_t tv[4];

  initial begin
    int cyc;
    int en;
    bit seen;
    bit d0;
    int dc[5];
    int dw[5];
    int nd;

    tv[0] = '{4'b0001, 5,  0, 8,  5};
    tv[1] = '{4'b0010, 0,  1, 3,  0};
    tv[2] = '{4'b1000, 15, 3, 18, 15};
    tv[3] = '{4'b0100, 1,  2, 4,  1};

    reset = 1'b0;
    req   = '0;
    tgt   = '0;
    frc   = 1'b0;
    model_reset();
    exp_done = '0;
    tick();
    tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clr", int'(cnt_clr), 1);
    chk("rst_q", int'(cnt_q), 0);
    reset = 1'b1;
    tick();

    // Single-request latency table.
    foreach (tv[v]) begin
      req = tv[v].r;
      tgt[tv[v].own*CW +: CW] = CW'(tv[v].t);
      cyc  = 0;
      en   = 0;
      seen = 0;
      while (!seen && cyc < 40) begin
        tick();
        cyc++;
        if (cnt_en) en++;
        if (done != '0) seen = 1;
      end
      chk("tv_done", int'(done), int'(tv[v].r));
      chk("tv_cyc", cyc, tv[v].done_cyc);
      chk("tv_en", en, tv[v].en_cyc);
      req = '0;
      tick();
      chk("tv_idle", int'(busy), 0);
    end

    // Round robin with all requests held.
    do_reset();
    for (int i = 0; i < N; i++) tgt[i*CW +: CW] = 4'd2;
    req = 4'b1111;
    cyc = 0;
    nd  = 0;
    while (nd < 5 && cyc < 80) begin
      tick();
      cyc++;
      if (done != '0) begin
        dc[nd] = cyc;
        dw[nd] = idx_of(done);
        nd++;
      end
    end
    req = '0;
    chk("rr_count", nd, 5);
    chk("rr_w0", dw[0], 0);
    chk("rr_w1", dw[1], 1);
    chk("rr_w2", dw[2], 2);
    chk("rr_w3", dw[3], 3);
    chk("rr_w4", dw[4], 0);
    chk("rr_first", dc[0], 5);
    for (int i = 1; i < 5; i++)
      chk("rr_space", dc[i] - dc[i-1], 6);
    tick();
    tick();

    // Abort of owner 0 at q=4 with req2 waiting.
    do_reset();
    tgt[0*CW +: CW] = 4'd10;
    tgt[2*CW +: CW] = 4'd3;
    req  = 4'b0001;
    seen = 0;
    d0   = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (busy && cnt_q == 4'd4) seen = 1;
    end
    chk("ab_wait", int'(seen), 1);
    req = 4'b0100;
    tick();
    chk("ab_gnt0", int'(gnt), 0);
    chk("ab_busy", int'(busy), 0);
    tick();
    chk("ab_gnt2", int'(gnt), 4);
    chk("ab_clr", int'(cnt_clr), 1);
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (done[0]) d0 = 1;
      if (done != '0) seen = 1;
    end
    chk("ab_done2", int'(done), 4);
    chk("ab_nodone0", int'(d0), 0);
    req = '0;
    tick();

    // Sticky err from a forced carry in COUNT.
    do_reset();
    tgt[0*CW +: CW] = 4'd6;
    req  = 4'b0001;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (busy && cnt_q == 4'd3) seen = 1;
    end
    chk("er_wait", int'(seen), 1);
    frc = 1'b1;
    tick();
    frc = 1'b0;
    chk("er_set", int'(err), 1);
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (done != '0) seen = 1;
    end
    chk("er_done", int'(done), 1);
    req = '0;
    tick();
    tick();
    chk("er_sticky", int'(err), 1);

    // Async reset mid-COUNT, err still set.
    tgt[1*CW +: CW] = 4'd12;
    req  = 4'b0010;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (busy && cnt_q == 4'd7) seen = 1;
    end
    chk("ar_wait", int'(seen), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_gnt", int'(gnt), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_err", int'(err), 0);
    chk("ar_clr", int'(cnt_clr), 1);
    model_reset();
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    tgt[1*CW +: CW] = 4'd1;
    tgt[2*CW +: CW] = 4'd1;
    req = 4'b0110;
    tick();
    chk("ar_ptr0", int'(gnt), 2);
    req = 4'b0010;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (done != '0) seen = 1;
    end
    chk("ar_fin", int'(seen), 1);
    req = '0;
    tick();

    // Randomized requesters with occasional aborts.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (exp_done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            req[i] = 1'b1;
            tgt[i*CW +: CW] = CW'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 60) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 20) == 0)
          tgt[i*CW +: CW] = CW'($urandom_range(0, 15));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
